// File: rtl/conv554_feeder.sv
// Streaming 5-row column feeder for a 4-channel 5x5 convolution unit.
// Optional sticky protocol-error flag enabled by CONV554_FEEDER_ERR_EN.
module conv554_feeder #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned IMG_W     = 12,
    parameter int unsigned IMG_H     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*BIT_WIDTH-1:0]    in_pix,
    output logic [20*BIT_WIDTH-1:0]   col_out,
    output logic                      col_en,
    output logic                      win_valid,
    output logic                      frame_done,
    output logic                      err
);

    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_D  = 4 * IMG_W;
    localparam int unsigned PIX_W = 4 * BIT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic [PIX_W-1:0]          r_lb [LB_D];
    logic [20*BIT_WIDTH-1:0]   r_col_out;
    logic [20*BIT_WIDTH-1:0]   w_col;
    logic                      r_col_en;
    logic                      r_win_valid;
    logic                      r_frame_done;
    logic                      w_accept;
    logic                      w_col_last;
    logic                      w_row_last;
    logic                      w_row_ge4;
    logic                      w_col_ge4;

    assign in_ready   = (r_state != DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_row_ge4  = (r_row >= RW'(4));
    assign w_col_ge4  = (r_col >= CW'(4));

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = FILL;
            FILL:    if (w_accept && w_col_last && (r_row == RW'(3))) w_state_nxt = STREAM;
            STREAM:  if (w_accept && w_col_last && w_row_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Raster position of the next beat; wraps to (0,0) after the last beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffer holds no reset: FILL rows overwrite it before any column is emitted
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0] <= in_pix;
            for (int j = 1; j < int'(LB_D); j++) begin
                r_lb[j] <= r_lb[j-1];
            end
        end
    end

    // Tap k*IMG_W holds the pixel k rows above the current one
    always_comb begin
        w_col = '0;
        for (int c = 0; c < 4; c++) begin
            w_col[BIT_WIDTH*(5*c+4) +: BIT_WIDTH] = in_pix[BIT_WIDTH*c +: BIT_WIDTH];
            for (int k = 1; k <= 4; k++) begin
                w_col[BIT_WIDTH*(5*c+4-k) +: BIT_WIDTH] =
                    r_lb[k*int'(IMG_W)-1][BIT_WIDTH*c +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_out    <= '0;
            r_col_en     <= 1'b0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_col_en     <= w_accept && w_row_ge4;
            r_win_valid  <= w_accept && w_row_ge4 && w_col_ge4;
            r_frame_done <= (w_state_nxt == DONE);
            if (w_accept && w_row_ge4) begin
                r_col_out <= w_col;
            end
        end
    end

    assign col_out    = r_col_out;
    assign col_en     = r_col_en;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

`ifdef CONV554_FEEDER_ERR_EN
    logic r_err;

    // Sticky: any beat offered while not ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv554_feeder.sv
// Directed self-checking bench for conv554_feeder (12x12 frames, 8-bit pixels).
module tb_conv554_feeder;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pix;
    logic [159:0] col_out;
    logic         col_en;
    logic         win_valid;
    logic         frame_done;
    logic         err;

    int n_chk;
    int n_pass;
    logic [159:0] exp_last;

    conv554_feeder #(.BIT_WIDTH(8), .IMG_W(12), .IMG_H(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .col_out    (col_out),
        .col_en     (col_en),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] px(input int r, input int cl, input int c, input bit neg);
        if (neg && c == 2) return 8'h80;
        return 8'(r * 12 + cl + c);
    endfunction

    function automatic logic [31:0] pack(input int r, input int cl, input bit neg);
        logic [31:0] p;
        for (int c = 0; c < 4; c++) p[8*c +: 8] = px(r, cl, c, neg);
        return p;
    endfunction

    // Drives one frame (optionally gapped); aborts with a reset at beat index abort_at
    task automatic drive_frame(input bit gaps, input bit neg, input bit hold, input int abort_at,
                               output int n_en, output int n_win, output int n_fd);
        logic [159:0] e;
        int idx;
        n_en = 0; n_win = 0; n_fd = 0; idx = 0;
        for (int r = 0; r < 12; r++) begin
            for (int cl = 0; cl < 12; cl++) begin
                if (gaps) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    n_chk++;
                    if (col_en !== 1'b0) $display("FAIL gap_col_en r=%0d c=%0d got %b want 0", r, cl, col_en);
                    else n_pass++;
                    n_chk++;
                    if (col_out !== exp_last) $display("FAIL gap_hold r=%0d c=%0d got %h want %h", r, cl, col_out, exp_last);
                    else n_pass++;
                end
                in_valid = 1'b1;
                in_pix   = pack(r, cl, neg);
                if (idx == abort_at) begin
                    #2 rst = 1'b0;
                    #1;
                    n_chk++;
                    if (in_ready !== 1'b1 || col_en !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0)
                        $display("FAIL midrst_flags got rdy=%b en=%b wv=%b fd=%b err=%b want 1 0 0 0 0",
                                 in_ready, col_en, win_valid, frame_done, err);
                    else n_pass++;
                    n_chk++;
                    if (col_out !== '0) $display("FAIL midrst_col_out got %h want 0", col_out);
                    else n_pass++;
                    in_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    @(posedge clk); #1;
                    exp_last = '0;
                    return;
                end
                n_chk++;
                if (in_ready !== 1'b1) $display("FAIL in_ready r=%0d c=%0d got %b want 1", r, cl, in_ready);
                else n_pass++;
                @(posedge clk); #1;
                if (col_en === 1'b1) n_en++;
                if (win_valid === 1'b1) n_win++;
                if (frame_done === 1'b1) n_fd++;
                n_chk++;
                if (col_en !== (r >= 4)) $display("FAIL col_en r=%0d c=%0d got %b want %b", r, cl, col_en, (r >= 4));
                else n_pass++;
                n_chk++;
                if (win_valid !== (r >= 4 && cl >= 4)) $display("FAIL win_valid r=%0d c=%0d got %b want %b", r, cl, win_valid, (r >= 4 && cl >= 4));
                else n_pass++;
                n_chk++;
                if (frame_done !== (r == 11 && cl == 11)) $display("FAIL frame_done r=%0d c=%0d got %b", r, cl, frame_done);
                else n_pass++;
                if (r >= 4) begin
                    for (int c = 0; c < 4; c++)
                        for (int rr = 0; rr < 5; rr++)
                            e[8*(5*c+rr) +: 8] = px(r - (4 - rr), cl, c, neg);
                    n_chk++;
                    if (col_out !== e) $display("FAIL col_out r=%0d c=%0d got %h want %h", r, cl, col_out, e);
                    else n_pass++;
                    exp_last = e;
                end
                if (!neg && r == 4 && cl == 0) begin
                    n_chk++;
                    if (col_out[39:0] !== 40'h30_24_18_0C_00) $display("FAIL first_ch0 got %h want 302418 0c00", col_out[39:0]);
                    else n_pass++;
                    n_chk++;
                    if (col_out[159:120] !== 40'h33_27_1B_0F_03) $display("FAIL first_ch3 got %h want 33271b0f03", col_out[159:120]);
                    else n_pass++;
                end
                if (neg && r >= 4) begin
                    n_chk++;
                    if (col_out[119:80] !== {5{8'h80}}) $display("FAIL neg_ch2 r=%0d c=%0d got %h want 8080808080", r, cl, col_out[119:80]);
                    else n_pass++;
                end
                idx++;
            end
        end
        // DONE cycle: beat presented here (if any) must be dropped
        in_valid = hold;
        in_pix   = pack(0, 0, neg);
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL done_ready got %b want 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1 || col_en !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL after_done got rdy=%b en=%b fd=%b want 1 0 0", in_ready, col_en, frame_done);
        else n_pass++;
    endtask

    task automatic check_counts(input string nm, input int n_en, input int n_win, input int n_fd);
        n_chk++;
        if (n_en !== 96) $display("FAIL %s_col_en_count got %0d want 96", nm, n_en);
        else n_pass++;
        n_chk++;
        if (n_win !== 64) $display("FAIL %s_win_count got %0d want 64", nm, n_win);
        else n_pass++;
        n_chk++;
        if (n_fd !== 1) $display("FAIL %s_frame_done_count got %0d want 1", nm, n_fd);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || col_en !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_flags got rdy=%b en=%b wv=%b fd=%b err=%b want 1 0 0 0 0",
                     in_ready, col_en, win_valid, frame_done, err);
        else n_pass++;
        n_chk++;
        if (col_out !== '0) $display("FAIL reset_col_out got %h want 0", col_out);
        else n_pass++;
        exp_last = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int a, b, c;
        drive_frame(1'b0, 1'b0, 1'b0, -1, a, b, c);
        check_counts("ramp", a, b, c);
        n_chk++;
        if (err !== 1'b0) $display("FAIL ramp_err got %b want 0", err);
        else n_pass++;
    endtask

    task automatic test_gapped();
        int a, b, c;
        drive_frame(1'b1, 1'b0, 1'b0, -1, a, b, c);
        check_counts("gapped", a, b, c);
    endtask

    task automatic test_negative();
        int a, b, c;
        drive_frame(1'b0, 1'b1, 1'b0, -1, a, b, c);
        check_counts("negative", a, b, c);
    endtask

    task automatic test_back_to_back();
        int a, b, c;
        logic exp_err;
        drive_frame(1'b0, 1'b0, 1'b1, -1, a, b, c);
        check_counts("b2b_first", a, b, c);
        drive_frame(1'b0, 1'b0, 1'b0, -1, a, b, c);
        check_counts("b2b_second", a, b, c);
`ifdef CONV554_FEEDER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n_chk++;
        if (err !== exp_err) $display("FAIL b2b_err got %b want %b", err, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int a, b, c;
        drive_frame(1'b0, 1'b0, 1'b0, 6 * 12 + 5, a, b, c);
        drive_frame(1'b0, 1'b0, 1'b0, -1, a, b, c);
        check_counts("after_reset", a, b, c);
        n_chk++;
        if (err !== 1'b0) $display("FAIL after_reset_err got %b want 0", err);
        else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_ramp();
        test_gapped();
        test_negative();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv554_feeder.md
# conv554_feeder

Streaming window feeder that sits upstream of the 4-channel 5x5 convolution unit. It accepts a raster-order pixel stream of 4 feature-map channels and buffers 4 image rows per channel. Every accepted pixel from row 4 onward produces one registered 5-pixel vertical column per channel, plus the latch enable the convolution unit consumes. It marks which columns complete a full 5x5 window and flags end of frame.

## Interface
- BIT_WIDTH, 8, pixel width per channel
- IMG_W, 12, image width in pixels (>= 5)
- IMG_H, 12, image height in rows (>= 5)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  feeder accepts beat this cycle
- in_pix  in  4*BIT_WIDTH  channel c at [BIT_WIDTH*c +: BIT_WIDTH], signed
- col_out  out  20*BIT_WIDTH  channel c, row r (r=0 top, r=4 bottom) at [BIT_WIDTH*(5c+r) +: BIT_WIDTH]
- col_en  out  1  col_out holds a new column; drives the convolution unit's en
- win_valid  out  1  this column completes a full 5x5 window
- frame_done  out  1  one-cycle pulse, last column of frame
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Beat accepted when in_valid && in_ready. Only accepted beats advance counters or line buffers.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1):
  - col increments per accepted beat and wraps to 0 at IMG_W-1.
  - row increments on col wrap.
  - Both clear to 0 after the final beat of a frame.
- Line buffer per channel is a 4*IMG_W-deep shift register, shifted only on accepted beats. For an accepted pixel at (row, col), the column is built as:
  - r4 = current pixel
  - r3 = tap 1*IMG_W
  - r2 = tap 2*IMG_W
  - r1 = tap 3*IMG_W
  - r0 = tap 4*IMG_W, i.e. the pixels at (row-k, col), where r = 4-k
- State machine, states IDLE, FILL, STREAM, DONE:
  - IDLE -> FILL on first accepted beat; that beat is (0,0).
  - FILL -> STREAM when beat (3, IMG_W-1) is accepted.
  - STREAM -> DONE when beat (IMG_H-1, IMG_W-1) is accepted.
  - DONE -> IDLE unconditionally on the next cycle.
- in_ready = 1 in IDLE/FILL/STREAM and 0 in DONE. It is combinational from state.
- col_en is registered: set after each beat accepted in STREAM, or on the transition edge from FILL into STREAM? No: set only for beats whose row >= 4.
- win_valid = col_en && (col of that beat >= 4).
- frame_done = 1 exactly while state is DONE. This coincides with the col_out/col_en of the last beat.
- Line-buffer contents are not reset. FILL rows overwrite them before any col_en, so stale data never reaches col_out.
- Arithmetic: no arithmetic on pixel data; values pass through bit-exact, sign preserved.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1
  - row = col = 0
  - col_out = 0, col_en = 0, win_valid = 0, frame_done = 0, err = 0
- Latency: 1 cycle from accepting edge to col_out/col_en/win_valid.
- Back-to-back beats: one column per cycle, no bubbles except the single DONE cycle between frames.
- Per frame:
  - (IMG_H-4)*IMG_W col_en pulses
  - (IMG_H-4)*(IMG_W-4) win_valid pulses
- Gaps (in_valid low) freeze counters and buffers. col_en is low in gap cycles. col_out holds its last value.
- in_valid during DONE: beat is not accepted and is dropped; err is handled per Configuration.
- Reset mid-frame: counters and state return to IDLE immediately (asynchronously). The next accepted beat is (0,0).

## Configuration
- CONV554_FEEDER_ERR_EN defined: err sets, one cycle after any cycle with in_valid=1 && in_ready=0 (i.e. in DONE). It stays set until rst.
- Undefined: err is tied to 0 and the detect logic is absent. All other behaviour is identical.

## Test plan
- Ramp frame, IMG_W=IMG_H=12, continuous valid, ch c pixel = row*12+col+c:
  - first col_en follows beat (4,0) with ch0 column {0,12,24,36,48}, ch3 column {3,15,27,39,51}
  - 96 col_en, 64 win_valid, 1 frame_done
- Window boundary: beats (4,3) and (4,4):
  - (4,3) gives col_en=1, win_valid=0
  - (4,4) gives col_en=1, win_valid=1
  - row 11 col 11 gives win_valid=1 together with frame_done=1
- Gapped input: in_valid toggling 1/0 through the frame gives the same 96 columns as the ramp test, in order; col_en never asserts in gap cycles.
- Negative data: ch2 constant -128 (0x80) gives every ch2 column slot equal to 0x80.
- Back-to-back frames with in_valid held high:
  - in_ready=0 for exactly one cycle (DONE); that beat is dropped
  - the second frame reproduces the first frame's results
  - with CONV554_FEEDER_ERR_EN, err=1 from then on; without it, err stays 0
- Reset mid-frame: assert rst at beat (6,5); all outputs return to their reset values. A full new frame after release gives exactly 96 col_en with correct data.
